// File: rtl/hsem_pkg.sv
// hsem_pkg: shared constants and types for the two-core hardware semaphore controller
package hsem_pkg;

    localparam int NUM_SEM_DEF = 8;
    localparam int SEM_IDW_DEF = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic OP_UNLOCK = 1'b0;
    localparam logic OP_LOCK   = 1'b1;

    localparam logic CORE0 = 1'b0;
    localparam logic CORE1 = 1'b1;

endpackage

// File: rtl/hsem_rr_arb.sv
// hsem_rr_arb: two-way round-robin arbiter; pointer moves to the loser on each grant
module hsem_rr_arb
    import hsem_pkg::*;
(
    input  logic       hclk,
    input  logic       hresetn,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    logic r_rr;

    // lone requester wins; on contention the rr pointer picks the core
    always_comb begin
        grant[0] = req[0] && (!req[1] || r_rr == CORE0);
        grant[1] = req[1] && (!req[0] || r_rr == CORE1);
    end

    // after a grant, point at the core that did not win
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn)
            r_rr <= CORE0;
        else if (advance)
            r_rr <= grant[0] ? CORE1 : CORE0;
    end

endmodule

// File: rtl/hsem_lock_ctrl.sv
// hsem_lock_ctrl: two-core hardware semaphore block with ownership, wait flags and release irq
module hsem_lock_ctrl
    import hsem_pkg::*;
#(
    parameter int NUM_SEM = NUM_SEM_DEF,
    parameter int SEM_IDW = SEM_IDW_DEF
) (
    input  logic               hclk,
    input  logic               hresetn,
    input  logic               req0,
    input  logic               req1,
    input  logic               op0,
    input  logic               op1,
    input  logic [SEM_IDW-1:0] sem_id0,
    input  logic [SEM_IDW-1:0] sem_id1,
    output logic               ack0,
    output logic               ack1,
    output logic               ok0,
    output logic               ok1,
    output logic               err0,
    output logic               err1,
    output logic [1:0]         rls_irq,
    output logic [NUM_SEM-1:0] sem_locked,
    output logic [NUM_SEM-1:0] sem_owner
);

    state_t r_state, w_next;
    logic [1:0] w_grant;
    logic w_start, w_exec;
    logic r_core, r_op;
    logic [SEM_IDW-1:0] r_sem_id;
    logic [NUM_SEM-1:0] r_locked, r_owner, w_mask;
    logic [1:0][NUM_SEM-1:0] r_wait;
    logic w_valid, w_held, w_mine, w_other_wait;
    logic w_ok, w_err, w_set_lock, w_clr, w_set_wait, w_irq;
    logic r_ack0, r_ack1, r_ok0, r_ok1, r_err0, r_err1;
    logic [1:0] r_irq;

    hsem_rr_arb u_arb (
        .hclk    (hclk),
        .hresetn (hresetn),
        .req     ({req1, req0}),
        .advance (w_start),
        .grant   (w_grant)
    );

    // state register
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn)
            r_state <= ST_IDLE;
        else
            r_state <= w_next;
    end

    // next state: a request starts an op, which always runs EXEC then RESP
    always_comb begin
        w_next = (r_state == ST_IDLE) ? ((req0 || req1) ? ST_EXEC : ST_IDLE) :
                 (r_state == ST_EXEC) ? ST_RESP : ST_IDLE;
    end

    // FSM decodes: grant strobe in IDLE, table update strobe in EXEC
    always_comb begin
        w_start = (r_state == ST_IDLE) && (|w_grant);
        w_exec  = (r_state == ST_EXEC);
    end

    // capture the winner's command so it survives a dropped request
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            r_core   <= CORE0;
            r_op     <= OP_UNLOCK;
            r_sem_id <= '0;
        end else if (w_start) begin
            r_core   <= w_grant[1];
            r_op     <= w_grant[1] ? op1 : op0;
            r_sem_id <= w_grant[1] ? sem_id1 : sem_id0;
        end
    end

    // decide the outcome of the latched op from the current tables
    always_comb begin
        w_valid      = int'(r_sem_id) < NUM_SEM;
        w_mask       = w_valid ? (NUM_SEM'(1) << r_sem_id) : '0;
        w_held       = |(r_locked & w_mask);
        w_mine       = w_held && ((|(r_owner & w_mask)) == r_core);
        w_other_wait = |(r_wait[~r_core] & w_mask);
        w_set_lock   = w_valid && r_op == OP_LOCK && !w_held;
        w_set_wait   = w_valid && r_op == OP_LOCK && w_held && !w_mine;
        w_clr        = r_op == OP_UNLOCK && w_mine;
        w_irq        = w_clr && w_other_wait;
        w_ok         = w_set_lock || w_mine;
        w_err        = !w_valid || (r_op == OP_UNLOCK && !w_mine);
    end

    // lock/owner/wait tables change only on the EXEC->RESP edge
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            r_locked <= '0;
            r_owner  <= '0;
            r_wait   <= '0;
        end else if (w_exec) begin
            if (w_set_lock) begin
                r_locked <= r_locked | w_mask;
                r_owner  <= r_core ? (r_owner | w_mask) : (r_owner & ~w_mask);
            end
            if (w_clr) begin
                r_locked <= r_locked & ~w_mask;
                r_owner  <= r_owner & ~w_mask;
            end
            if (w_set_wait)
                r_wait[r_core] <= r_wait[r_core] | w_mask;
            if (w_irq)
                r_wait[~r_core] <= r_wait[~r_core] & ~w_mask;
        end
    end

    // response pulses are registered so they are high only while in RESP
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            r_ack0 <= 1'b0;
            r_ack1 <= 1'b0;
            r_ok0  <= 1'b0;
            r_ok1  <= 1'b0;
            r_err0 <= 1'b0;
            r_err1 <= 1'b0;
            r_irq  <= 2'b00;
        end else begin
            r_ack0 <= w_exec && r_core == CORE0;
            r_ack1 <= w_exec && r_core == CORE1;
            r_ok0  <= w_exec && r_core == CORE0 && w_ok;
            r_ok1  <= w_exec && r_core == CORE1 && w_ok;
            r_err0 <= w_exec && r_core == CORE0 && w_err;
            r_err1 <= w_exec && r_core == CORE1 && w_err;
            r_irq  <= (w_exec && w_irq) ? (r_core == CORE0 ? 2'b10 : 2'b01) : 2'b00;
        end
    end

    assign ack0       = r_ack0;
    assign ack1       = r_ack1;
    assign ok0        = r_ok0;
    assign ok1        = r_ok1;
    assign err0       = r_err0;
    assign err1       = r_err1;
    assign rls_irq    = r_irq;
    assign sem_locked = r_locked;
    assign sem_owner  = r_owner;

endmodule

// File: tb/tb_hsem_lock_ctrl.sv
// tb_hsem_lock_ctrl: scoreboard bench with a behavioural semaphore model and random two-core traffic
module tb_hsem_lock_ctrl;

    localparam int NS = 6;

    typedef struct {
        int       cyc;
        bit       ok;
        bit       err;
        bit [1:0] irq;
        bit [NS-1:0] locked;
        bit [NS-1:0] owner;
    } exp_t;

    logic hclk, hresetn;
    bit rq[2];
    bit op[2];
    logic [2:0] sid[2];
    logic ack0, ack1, ok0, ok1, err0, err1;
    logic [1:0] rls_irq;
    logic [NS-1:0] sem_locked, sem_owner;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int free_at = 0;
    int rr = 0;
    int owner_of[8];
    bit waiting[2][8];
    exp_t q0[$];
    exp_t q1[$];
    bit got_ok[2];
    bit got_err[2];
    int gap[2];

    hsem_lock_ctrl #(.NUM_SEM(NS), .SEM_IDW(3)) dut (
        .hclk       (hclk),
        .hresetn    (hresetn),
        .req0       (rq[0]),
        .req1       (rq[1]),
        .op0        (op[0]),
        .op1        (op[1]),
        .sem_id0    (sid[0]),
        .sem_id1    (sid[1]),
        .ack0       (ack0),
        .ack1       (ack1),
        .ok0        (ok0),
        .ok1        (ok1),
        .err0       (err0),
        .err1       (err1),
        .rls_irq    (rls_irq),
        .sem_locked (sem_locked),
        .sem_owner  (sem_owner)
    );

    initial begin
        hclk = 0;
        forever #5 hclk = ~hclk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            owner_of[i] = -1;
            waiting[0][i] = 0;
            waiting[1][i] = 0;
        end
        rr = 0;
        free_at = 0;
        q0.delete();
        q1.delete();
    endtask

    // semaphore semantics in terms of an owner-per-semaphore array
    task automatic model_op(input int c, input bit o, input int id, output exp_t e);
        e.ok = 0;
        e.err = 0;
        e.irq = 0;
        if (id >= NS) e.err = 1;
        else if (o) begin
            if (owner_of[id] < 0) begin
                owner_of[id] = c;
                e.ok = 1;
            end else if (owner_of[id] == c) e.ok = 1;
            else waiting[c][id] = 1;
        end else if (owner_of[id] == c) begin
            owner_of[id] = -1;
            e.ok = 1;
            if (waiting[1-c][id]) begin
                waiting[1-c][id] = 0;
                e.irq[1-c] = 1;
            end
        end else e.err = 1;
        for (int i = 0; i < NS; i++) begin
            e.locked[i] = owner_of[i] >= 0;
            e.owner[i] = owner_of[i] == 1;
        end
    endtask

    // reference: one grant every 3 cycles, answer visible one cycle after the grant edge
    always @(posedge hclk) begin
        exp_t e;
        int w;
        cyc++;
        if (!hresetn) model_reset();
        else if (cyc >= free_at && (rq[0] || rq[1])) begin
            w = (rq[0] && rq[1]) ? rr : (rq[0] ? 0 : 1);
            rr = 1 - w;
            model_op(w, op[w], int'(sid[w]), e);
            e.cyc = cyc + 1;
            if (w == 0) q0.push_back(e);
            else q1.push_back(e);
            free_at = cyc + 3;
        end
    end

    task automatic mon(input int c, input logic a, input logic ok, input logic err);
        exp_t e;
        int n = (c == 0) ? q0.size() : q1.size();
        if (a && n == 0) check($sformatf("ack%0d_unexpected", c), 32'(a), 0);
        else if (a) begin
            if (c == 0) e = q0.pop_front();
            else e = q1.pop_front();
            check($sformatf("ack%0d_cycle", c), cyc, e.cyc);
            check($sformatf("ok%0d", c), 32'(ok), 32'(e.ok));
            check($sformatf("err%0d", c), 32'(err), 32'(e.err));
            check($sformatf("rls_irq_at_ack%0d", c), 32'(rls_irq), 32'(e.irq));
            check($sformatf("sem_locked_at_ack%0d", c), 32'(sem_locked), 32'(e.locked));
            check($sformatf("sem_owner_at_ack%0d", c), 32'(sem_owner), 32'(e.owner));
        end else if (n > 0) begin
            if (c == 0 && q0[0].cyc < cyc) begin
                check("ack0_missing", 32'(a), 1);
                void'(q0.pop_front());
            end
            if (c == 1 && q1[0].cyc < cyc) begin
                check("ack1_missing", 32'(a), 1);
                void'(q1.pop_front());
            end
        end
    endtask

    // monitor samples on the falling edge, away from the active edge
    always @(negedge hclk) begin
        mon(0, ack0, ok0, err0);
        mon(1, ack1, ok1, err1);
        if (!ack0 && !ack1) check("rls_irq_idle", 32'(rls_irq), 0);
    end

    task automatic check_all_zero(input string name);
        check(name, 32'({ack0, ack1, ok0, ok1, err0, err1, rls_irq}), 0);
        check({name, "_tables"}, 32'({sem_locked, sem_owner}), 0);
    endtask

    task automatic do_reset();
        @(negedge hclk);
        hresetn = 0;
        rq[0] = 0;
        rq[1] = 0;
        @(negedge hclk);
        check_all_zero("reset_outputs");
        @(negedge hclk);
        hresetn = 1;
    endtask

    // hold requests until the matching ack, recording the reported result
    task automatic issue(input bit r0, input bit r1, input bit o0, input bit o1, input int s0, input int s1);
        bit done = 0;
        rq[0] = r0;
        rq[1] = r1;
        op[0] = o0;
        op[1] = o1;
        sid[0] = 3'(s0);
        sid[1] = 3'(s1);
        for (int k = 0; k < 30 && !done; k++) begin
            @(negedge hclk);
            if (rq[0] && ack0) begin
                rq[0] = 0;
                got_ok[0] = ok0;
                got_err[0] = err0;
            end
            if (rq[1] && ack1) begin
                rq[1] = 0;
                got_ok[1] = ok1;
                got_err[1] = err1;
            end
            done = !rq[0] && !rq[1];
        end
        if (!done) check("issue_timeout", 32'({rq[0], rq[1]}), 0);
        rq[0] = 0;
        rq[1] = 0;
    endtask

    initial begin
        hresetn = 0;
        rq[0] = 0;
        rq[1] = 0;
        op[0] = 0;
        op[1] = 0;
        sid[0] = 0;
        sid[1] = 0;
        model_reset();
        repeat (3) @(negedge hclk);
        check_all_zero("power_on_reset");
        hresetn = 1;
        @(negedge hclk);

        issue(1, 0, 1, 0, 3, 0);
        check("lock3_ok0", 32'(got_ok[0]), 1);
        check("lock3_locked", 32'(sem_locked), 32'h08);
        check("lock3_owner", 32'(sem_owner), 32'h00);

        do_reset();
        issue(1, 1, 1, 1, 5, 5);
        check("contend_ok0", 32'(got_ok[0]), 1);
        check("contend_ok1", 32'(got_ok[1]), 0);
        check("contend_locked", 32'(sem_locked), 32'h20);
        check("contend_owner", 32'(sem_owner), 32'h00);

        issue(1, 0, 0, 0, 5, 0);
        check("release_ok0", 32'(got_ok[0]), 1);
        check("release_locked", 32'(sem_locked), 32'h00);

        issue(1, 0, 1, 0, 2, 0);
        issue(0, 1, 0, 0, 0, 2);
        check("foreign_unlock_ok1", 32'(got_ok[1]), 0);
        check("foreign_unlock_err1", 32'(got_err[1]), 1);
        check("foreign_unlock_locked2", 32'(sem_locked[2]), 1);

        issue(1, 0, 1, 0, 7, 0);
        check("bad_id_ok0", 32'(got_ok[0]), 0);
        check("bad_id_err0", 32'(got_err[0]), 1);

        gap[0] = 0;
        gap[1] = 0;
        repeat (3000) begin
            @(negedge hclk);
            for (int c = 0; c < 2; c++) begin
                if (rq[c]) begin
                    if ((c == 0 && ack0) || (c == 1 && ack1)) begin
                        rq[c] = 0;
                        gap[c] = $urandom_range(0, 3);
                    end
                end else if (gap[c] > 0) gap[c]--;
                else if ($urandom_range(0, 3) != 0) begin
                    rq[c] = 1;
                    op[c] = 1'($urandom_range(0, 1));
                    sid[c] = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 7));
                end
            end
        end
        for (int k = 0; k < 40 && (rq[0] || rq[1]); k++) begin
            @(negedge hclk);
            if (rq[0] && ack0) rq[0] = 0;
            if (rq[1] && ack1) rq[1] = 0;
        end
        rq[0] = 0;
        rq[1] = 0;
        repeat (4) @(negedge hclk);

        issue(0, 1, 0, 1, 0, 4);
        check("pre_abort_locked4", 32'(sem_locked[4]), 1);
        rq[0] = 1;
        op[0] = 1;
        sid[0] = 3'd1;
        @(posedge hclk);
        @(negedge hclk);
        hresetn = 0;
        rq[0] = 0;
        #1;
        check_all_zero("abort_in_exec");
        repeat (2) @(negedge hclk);
        check_all_zero("abort_held");
        hresetn = 1;
        repeat (6) @(negedge hclk);
        check("abort_no_ack", 32'({ack0, ack1}), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
